// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : RV32I load/store responder on a word array with programmable
//            wait states and valid/ready request and response channels.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int c_AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic [31:0]     w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic            w_oor;
    logic            w_misalign;
    logic            w_illegal;
    logic            w_st_bad;
    logic            w_err;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;
    logic            w_access;
    logic            w_wr_en;

    assign w_idx    = r_addr[c_AW+1:2];
    assign w_lane   = r_addr[1:0];
    assign w_word   = r_mem[w_idx];
    assign w_byte   = w_word[{w_lane, 3'b000} +: 8];
    assign w_half   = r_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_oor    = (r_addr >> (c_AW + 2)) != 32'd0;
    assign w_err    = w_oor | w_misalign | w_illegal | (r_we & w_st_bad);
    assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_wr_en  = w_access && r_we && !w_err && rst;

    // Width decode: alignment, load extension and store byte-enable/lane replication.
    always_comb begin
        w_misalign = 1'b0;
        w_illegal  = 1'b0;
        w_st_bad   = 1'b0;
        w_load     = 32'd0;
        w_be       = 4'b0000;
        w_wd       = r_wdata;
        case (r_funct3)
            3'b000: begin
                w_load = {{24{w_byte[7]}}, w_byte};
                w_be   = 4'b0001 << w_lane;
                w_wd   = {4{r_wdata[7:0]}};
            end
            3'b100: begin
                w_load   = {24'd0, w_byte};
                w_st_bad = 1'b1;
            end
            3'b001: begin
                w_misalign = r_addr[0];
                w_load     = {{16{w_half[15]}}, w_half};
                w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wd       = {2{r_wdata[15:0]}};
            end
            3'b101: begin
                w_misalign = r_addr[0];
                w_load     = {16'd0, w_half};
                w_st_bad   = 1'b1;
            end
            3'b010: begin
                w_misalign = |r_addr[1:0];
                w_load     = w_word;
                w_be       = 4'b1111;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Array is intentionally not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_cnt    <= 4'(WAIT_CYCLES);
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err   <= w_err;
                        r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_resp
// Brief    : Scoreboard bench for data_mem_resp with 2 and 0 wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam logic [2:0] c_F_B  = 3'b000;
    localparam logic [2:0] c_F_H  = 3'b001;
    localparam logic [2:0] c_F_W  = 3'b010;
    localparam logic [2:0] c_F_BU = 3'b100;
    localparam logic [2:0] c_F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_ready;
    logic        sel;

    logic        w_req_valid_2, w_req_ready_2, w_rsp_valid_2, w_rsp_err_2;
    logic        w_req_valid_0, w_req_ready_0, w_rsp_valid_0, w_rsp_err_0;
    logic [31:0] w_rsp_rdata_2, w_rsp_rdata_0;
    logic        w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_rsp_rdata;

    always #5 clk = ~clk;

    assign w_req_valid_2 = req_valid && !sel;
    assign w_req_valid_0 = req_valid && sel;
    assign w_req_ready   = sel ? w_req_ready_0 : w_req_ready_2;
    assign w_rsp_valid   = sel ? w_rsp_valid_0 : w_rsp_valid_2;
    assign w_rsp_err     = sel ? w_rsp_err_0   : w_rsp_err_2;
    assign w_rsp_rdata   = sel ? w_rsp_rdata_0 : w_rsp_rdata_2;

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid_2), .req_ready(w_req_ready_2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid(w_rsp_valid_2), .rsp_ready(rsp_ready),
        .rsp_rdata(w_rsp_rdata_2), .rsp_err(w_rsp_err_2)
    );

    data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid_0), .req_ready(w_req_ready_0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3),
        .rsp_valid(w_rsp_valid_0), .rsp_ready(rsp_ready),
        .rsp_rdata(w_rsp_rdata_0), .rsp_err(w_rsp_err_0)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_now = 2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3);
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic send(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
        sb.push_back(exp_t'{err: exp_err, rdata: exp_rdata});
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(w_req_ready), 32'd1);
        drive_req(we, addr, wdata, f3);
    endtask

    task automatic wait_rsp(input string tag);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (w_rsp_valid) got = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), 32'(wait_now + 1));
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed response expected none queued", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, w_rsp_rdata, e.rdata);
            chk({tag, "_err"}, 32'(w_rsp_err), 32'(e.err));
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
        send(tag, we, addr, wdata, f3, exp_rdata, exp_err);
        wait_rsp(tag);
        check_rsp(tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, {30'd0, w_rsp_valid, w_req_ready}, 32'd1);
    endtask

    task automatic reset_mid(input logic which, input int w);
        int seen;
        sel      = which;
        wait_now = w;
        xact("rst_sw1", 1'b1, 32'h20, 32'h1111_1111, c_F_W, 32'd0, 1'b0);
        drive_req(1'b1, 32'h20, 32'h2222_2222, c_F_W);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(w_rsp_valid), 32'd0);
        chk("rst_mid_ready", 32'(w_req_ready), 32'd1);
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (w_rsp_valid) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        xact("rst_lw", 1'b0, 32'h20, 32'd0, c_F_W, 32'h1111_1111, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFF_FFFF;
        req_funct3 = c_F_W;
        rsp_ready  = 1'b1;
        sel        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_ready", 32'(w_req_ready), 32'd1);
            chk("reset_valid", 32'(w_rsp_valid), 32'd0);
            chk("reset_rdata", w_rsp_rdata, 32'd0);
            chk("reset_err", 32'(w_rsp_err), 32'd0);
        end
        sel       = 1'b0;
        req_valid = 1'b0;
        rst       = 1'b1;

        xact("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, c_F_W, 32'd0, 1'b0);
        xact("lw10", 1'b0, 32'h10, 32'd0, c_F_W, 32'hDEAD_BEEF, 1'b0);

        xact("lb13",  1'b0, 32'h13, 32'd0, c_F_B,  32'hFFFF_FFDE, 1'b0);
        xact("lbu13", 1'b0, 32'h13, 32'd0, c_F_BU, 32'h0000_00DE, 1'b0);
        xact("lh12",  1'b0, 32'h12, 32'd0, c_F_H,  32'hFFFF_DEAD, 1'b0);
        xact("lhu10", 1'b0, 32'h10, 32'd0, c_F_HU, 32'h0000_BEEF, 1'b0);
        xact("lb10",  1'b0, 32'h10, 32'd0, c_F_B,  32'hFFFF_FFEF, 1'b0);

        xact("sb11",    1'b1, 32'h11, 32'h1234_56AA, c_F_B, 32'd0, 1'b0);
        xact("lw_sb",   1'b0, 32'h10, 32'd0, c_F_W, 32'hDEAD_AAEF, 1'b0);
        xact("sh12",    1'b1, 32'h12, 32'hFFFF_1234, c_F_H, 32'd0, 1'b0);
        xact("lw_sh",   1'b0, 32'h10, 32'd0, c_F_W, 32'h1234_AAEF, 1'b0);

        xact("err_lw12",  1'b0, 32'h12,   32'd0,        c_F_W,  32'd0, 1'b1);
        xact("err_sh11",  1'b1, 32'h11,   32'h5555_5555, c_F_H, 32'd0, 1'b1);
        xact("lw_after_sh11", 1'b0, 32'h10, 32'd0, c_F_W, 32'h1234_AAEF, 1'b0);
        xact("err_oor",   1'b0, 32'h1000, 32'd0,        c_F_W,  32'd0, 1'b1);
        xact("err_f3",    1'b0, 32'h10,   32'd0,        3'b011, 32'd0, 1'b1);
        xact("err_sbu",   1'b1, 32'h10,   32'h0000_0077, c_F_BU, 32'd0, 1'b1);
        xact("lw_after_sbu", 1'b0, 32'h10, 32'd0, c_F_W, 32'h1234_AAEF, 1'b0);

        // Backpressure with a competing store presented while the response stalls.
        rsp_ready = 1'b0;
        send("bp", 1'b0, 32'h10, 32'd0, c_F_W, 32'h1234_AAEF, 1'b0);
        wait_rsp("bp");
        req_we     = 1'b1;
        req_addr   = 32'h10;
        req_wdata  = 32'd0;
        req_funct3 = c_F_W;
        req_valid  = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", 32'(w_rsp_valid), 32'd1);
            chk("bp_hold_rdata", w_rsp_rdata, 32'h1234_AAEF);
            chk("bp_hold_err", 32'(w_rsp_err), 32'd0);
            chk("bp_hold_ready", 32'(w_req_ready), 32'd0);
        end
        check_rsp("bp");
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release", {30'd0, w_rsp_valid, w_req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_single_hs", {30'd0, w_rsp_valid, w_req_ready}, 32'd1);
        xact("bp_no_store", 1'b0, 32'h10, 32'd0, c_F_W, 32'h1234_AAEF, 1'b0);

        reset_mid(1'b0, 2);
        reset_mid(1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
Data-memory responder for the RISC-V core's load/store path. It accepts one load or store request at a time over a valid/ready request channel and performs it on an internal word-organised array. A programmable number of wait states models slow memory. It returns the load data, or a store acknowledgement, over a valid/ready response channel, with RV32I byte, halfword and word sizing and sign/zero extension.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two, minimum 4.
WAIT_CYCLES, 2, extra wait-state cycles per access; range 0..15.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data; low bits used for SB/SH
req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request rejected: misaligned, out of range or illegal funct3

Behaviour:
- FSM states: IDLE, BUSY, RESP. Wait counter is 4 bits.
- req_ready = (state == IDLE). rsp_valid = (state == RESP).
- Reset (rst = 0, asynchronous): state = IDLE, counter = 0, rsp_rdata = 0, rsp_err = 0. req_ready therefore reads 1 and rsp_valid reads 0. Array contents are not reset.
- IDLE: when req_valid & req_ready on an edge, register req_we, req_addr, req_wdata and req_funct3. Load counter with WAIT_CYCLES and go to BUSY.
- BUSY, counter != 0: decrement the counter.
- BUSY, counter == 0: perform the access, register rsp_rdata and rsp_err, go to RESP.
- Latency: rsp_valid is first high after the (WAIT_CYCLES+1)th rising edge following the accepting edge.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready is high on an edge. That edge returns the FSM to IDLE. There is no back-to-back acceptance; req_valid is ignored outside IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0].
- Error conditions, any one sets rsp_err = 1:
  - addr >= 4*DEPTH_WORDS
  - H/HU with addr[0] = 1
  - W with addr[1:0] != 0
  - funct3 in {011, 110, 111}
  - store with funct3 in {100, 101}
- On error: no array write, rsp_rdata = 0.
- Loads:
  - B/BU: select the byte at the lane, sign-extend (B) or zero-extend (BU).
  - H/HU: select the halfword at addr[1], sign-extend (H) or zero-extend (HU).
  - W: the full word.
- Stores:
  - SB writes only the lane byte with wdata[7:0].
  - SH writes the halfword at addr[1] with wdata[15:0].
  - SW writes all 4 bytes.
  - Other bytes of the word are preserved. A store response has rsp_rdata = 0, rsp_err = 0.
- The array write happens only on the BUSY→RESP edge.
- Reset during BUSY: the request is dropped, no write occurs, and no response is given.
- Reset during RESP: the write has already been committed; the response is dropped.
- req_valid high during reset is ignored. The first acceptance is the first edge with rst = 1, req_valid = 1.

Test Plan:
(WAIT_CYCLES = 2, rsp_ready = 1 unless stated.)
1. SW addr 0x10, wdata 0xDEADBEEF, funct3 010 → rsp_valid first high after 3rd edge post-accept, rsp_err 0, rsp_rdata 0. Then LW 0x10 → rsp_rdata 0xDEADBEEF.
2. From state 1:
   - LB 0x13 → 0xFFFFFFDE
   - LBU 0x13 → 0x000000DE
   - LH 0x12 → 0xFFFFDEAD
   - LHU 0x10 → 0x0000BEEF
   - LB 0x10 → 0xFFFFFFEF
3. SB 0x11, wdata 0x123456AA → LW 0x10 = 0xDEADAAEF. Then SH 0x12, wdata 0xFFFF1234 → LW 0x10 = 0x1234AAEF.
4. Errors, each → rsp_err 1, rsp_rdata 0:
   - LW 0x12
   - SH 0x11 (then LW 0x10 unchanged = 0x1234AAEF)
   - LW 0x1000 (= 4*DEPTH_WORDS)
   - funct3 011
   - SB with funct3 100
5. Backpressure: LW 0x10 with rsp_ready held 0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay constant, req_ready stays 0, and a concurrent req_valid is not accepted. On rsp_ready = 1, exactly one handshake occurs, then req_ready = 1.
6. Reset mid-operation:
   - SW 0x20 = 0x11111111 completes.
   - SW 0x20 = 0x22222222 is accepted; rst pulsed low during BUSY → rsp_valid 0, req_ready 1 immediately.
   - After release, LW 0x20 → 0x11111111.
   - Repeat with WAIT_CYCLES = 0: response follows 1 edge after accept.
